// File: rtl/calc2_pkg.sv
// Shared types for the calc2 port agent: command/response codes, tags and the
// queued result record.
package calc2_pkg;

  localparam int NUM_TAGS = 4;

  typedef logic [1:0] tag_t;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    OK      = 2'd1,
    ERR     = 2'd2,
    TIMEOUT = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } agent_state_e;

  typedef struct packed {
    resp_e       resp;
    logic [31:0] data;
    tag_t        tag;
  } result_t;

  // Lowest index whose bit is clear; returns 0 when none is clear.
  function automatic tag_t lowest_free(logic [NUM_TAGS-1:0] busy);
    tag_t t;
    t = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) t = tag_t'(i);
    end
    return t;
  endfunction

  function automatic logic [NUM_TAGS-1:0] tag_onehot(tag_t t);
    return NUM_TAGS'(1) << t;
  endfunction

endpackage

// File: rtl/calc2_result_fifo.sv
// Result queue: synchronous FIFO of result_t records with wrapping pointers.
module calc2_result_fifo
  import calc2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    c_clk,
  input  logic    reset,
  input  logic    push,
  input  result_t push_data,
  input  logic    pop,
  output result_t head,
  output logic    empty,
  output logic    full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  result_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/calc2_port_agent.sv
// Upstream agent for one calc2 port: serialises (cmd, A, B) into the two-beat
// request protocol under a tag, and queues tagged responses or local timeouts.
//
//   state  | meaning
//   IDLE   | no request beat on the port
//   SEND_A | beat 1: cmd, operand A, tag
//   SEND_B | beat 2: cmd 0, operand B, tag; next op may be accepted
module calc2_port_agent
  import calc2_pkg::*;
#(
  parameter int TIMEOUT    = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_cmd,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  output logic [1:0]  req_tag_out,
  input  logic [1:0]  resp_in,
  input  logic [31:0] resp_data_in,
  input  logic [1:0]  resp_tag_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:0]  res_resp,
  output logic [31:0] res_data,
  output logic [1:0]  res_tag,
  output logic [3:0]  tags_busy,
  output logic        spurious_err
);

  agent_state_e        state_q, state_nxt;
  logic [31:0]         b_q;
  tag_t                tag_q, alloc_tag, tmo_tag;
  logic [NUM_TAGS-1:0] wait_q, run_q, expired, alloc_mask, answer_mask, free_mask, busy_nxt;
  logic [7:0]          tmr_q [NUM_TAGS];
  logic                take, resp_hit, push, pop, ready_nxt, fifo_empty, fifo_full;
  result_t             push_data, head;

  // cmd 0 is swallowed: handshake completes but nothing is sent or allocated
  assign take       = op_valid && op_ready && (op_cmd != NOP);
  assign alloc_tag  = lowest_free(tags_busy);
  assign alloc_mask = take ? tag_onehot(alloc_tag) : '0;
  assign resp_hit   = (resp_in != 2'b00) && tags_busy[resp_tag_in] && wait_q[resp_tag_in];
  assign tmo_tag    = lowest_free(~expired);
  assign pop        = res_valid && res_ready;
  assign free_mask  = pop ? tag_onehot(head.tag) : '0;
  assign busy_nxt   = (tags_busy | alloc_mask) & ~free_mask;
  assign ready_nxt  = (state_nxt != SEND_A) && (busy_nxt != '1);

  always_comb begin
    expired = '0;
    for (int i = 0; i < NUM_TAGS; i++)
      expired[i] = wait_q[i] && run_q[i] && (tmr_q[i] == 8'd0);
  end

  // One push per cycle: a real response beats any timeout, which stays pending.
  always_comb begin
    push        = 1'b0;
    answer_mask = '0;
    push_data   = '{resp: calc2_pkg::TIMEOUT, data: 32'd0, tag: tmo_tag};
    if (resp_hit) begin
      push        = 1'b1;
      answer_mask = tag_onehot(resp_tag_in);
      push_data   = '{resp: resp_e'(resp_in), data: resp_data_in, tag: resp_tag_in};
    end else if (|expired) begin
      push        = 1'b1;
      answer_mask = tag_onehot(tmo_tag);
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (take) state_nxt = SEND_A;
      SEND_A:  state_nxt = SEND_B;
      SEND_B:  state_nxt = take ? SEND_A : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      op_ready     <= 1'b0;
      tags_busy    <= '0;
      wait_q       <= '0;
      spurious_err <= 1'b0;
      b_q          <= '0;
      tag_q        <= '0;
      req_cmd_out  <= '0;
      req_data_out <= '0;
      req_tag_out  <= '0;
    end else begin
      op_ready  <= ready_nxt;
      tags_busy <= busy_nxt;
      wait_q    <= (wait_q | alloc_mask) & ~answer_mask;
      if ((resp_in != 2'b00) && !resp_hit) spurious_err <= 1'b1;
      if (take) begin
        b_q   <= op_b;
        tag_q <= alloc_tag;
      end
      case (state_nxt)
        SEND_A: begin
          req_cmd_out  <= op_cmd;
          req_data_out <= op_a;
          req_tag_out  <= alloc_tag;
        end
        SEND_B: begin
          req_cmd_out  <= '0;
          req_data_out <= b_q;
          req_tag_out  <= tag_q;
        end
        default: begin
          req_cmd_out  <= '0;
          req_data_out <= '0;
          req_tag_out  <= '0;
        end
      endcase
    end
  end

  // Timer is armed on the edge that puts the B beat out; a reallocated tag is disarmed.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      run_q <= '0;
      for (int i = 0; i < NUM_TAGS; i++) tmr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (alloc_mask[i]) begin
          run_q[i] <= 1'b0;
        end else if ((state_q == SEND_A) && (tag_q == tag_t'(i))) begin
          run_q[i] <= 1'b1;
          tmr_q[i] <= 8'(TIMEOUT - 1);
        end else if (answer_mask[i]) begin
          run_q[i] <= 1'b0;
        end else if (run_q[i] && (tmr_q[i] != 8'd0)) begin
          tmr_q[i] <= tmr_q[i] - 8'd1;
        end
      end
    end
  end

  calc2_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .c_clk     (c_clk),
    .reset     (reset),
    .push      (push && !fifo_full),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign res_valid = !fifo_empty;
  assign res_resp  = head.resp;
  assign res_data  = head.data;
  assign res_tag   = head.tag;

endmodule
